// File: rtl/sc_random_row_gen_pkg.sv
// Shared encodings and constants for the random obstacle-row generator.
package sc_random_row_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StLoad = 2'b10,
    StEmit = 2'b11
  } state_e;

  localparam logic [1:0] Lvl1 = 2'b01;
  localparam logic [1:0] Lvl2 = 2'b10;
  localparam logic [1:0] Lvl3 = 2'b11;

  localparam logic [15:0] DefaultSeed = 16'hACE1;

  // Fibonacci step, taps 16,14,13,11; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/sc_random_row_gen_lfsr.sv
// Free-running 16-bit LFSR; a zero seed is replaced by the default seed.
module sc_lfsr16
  import sc_random_row_gen_pkg::*;
#(
  parameter logic [15:0] Seed = DefaultSeed
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] value_o
);

  localparam logic [15:0] SeedEff = (Seed == 16'h0000) ? DefaultSeed : Seed;

  logic [15:0] lfsr_q, lfsr_d;

  // Advance one step every clock.
  always_comb begin
    lfsr_d = lfsr16_next(lfsr_q);
  end

  // State register, reloads the seed on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SeedEff;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/sc_random_row_gen.sv
// Emits one pseudo-random obstacle row per scroll tick while generation is enabled.
module sc_random_row_gen
  import sc_random_row_gen_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter logic [15:0] SEED   = DefaultSeed,
  parameter int unsigned GAP_L1 = 3,
  parameter int unsigned GAP_L2 = 2,
  parameter int unsigned GAP_L3 = 1
) (
  input  logic             SC_STATEMACHINE_RANDOM_CLOCK_50,
  input  logic             SC_STATEMACHINE_RANDOM_RESET_InLow,
  input  logic             SC_RANDOM_ROW_GEN_SELECTION,
  input  logic             SC_RANDOM_ROW_GEN_DOWN_InLow,
  input  logic [1:0]       SC_RANDOM_ROW_GEN_LEVEL_InLow,
  output logic [LANES-1:0] SC_RANDOM_ROW_GEN_ROW,
  output logic             SC_RANDOM_ROW_GEN_ROW_VALID,
  output logic [7:0]       SC_RANDOM_ROW_GEN_COUNT
);

  localparam int unsigned LaneBits = $clog2(LANES);

  logic             clk, rst_n, sel, down_n;
  logic [1:0]       level;

  assign clk    = SC_STATEMACHINE_RANDOM_CLOCK_50;
  assign rst_n  = SC_STATEMACHINE_RANDOM_RESET_InLow;
  assign sel    = SC_RANDOM_ROW_GEN_SELECTION;
  assign down_n = SC_RANDOM_ROW_GEN_DOWN_InLow;
  assign level  = SC_RANDOM_ROW_GEN_LEVEL_InLow;

  state_e           state_q, state_d;
  logic             down_q, down_d;
  logic [LANES-1:0] row_q, row_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       count_q, count_d;

  logic [15:0]         lfsr;
  logic                tick;
  logic [LaneBits-1:0] lane_a, lane_b;
  logic [LANES-1:0]    candidate;
  logic [7:0]          gap_reload;
  logic                unused_lfsr_bits;

  sc_lfsr16 #(
    .Seed (SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .value_o (lfsr)
  );

  assign lane_a           = lfsr[LaneBits-1:0];
  assign lane_b           = lfsr[2*LaneBits-1:LaneBits];
  assign unused_lfsr_bits = ^lfsr[15:2*LaneBits];

  // Falling edge of the scroll input, one cycle wide.
  always_comb begin
    down_d = down_n;
    tick   = down_q & ~down_n;
  end

  // Candidate row: one car, plus a second (possibly the same lane) at level 3.
  always_comb begin
    candidate = LANES'(1) << lane_a;
    if (level == Lvl3) begin
      candidate = candidate | (LANES'(1) << lane_b);
    end
  end

  // Empty-row spacing for the current level; 00 behaves like level 1.
  always_comb begin
    case (level)
      Lvl2:    gap_reload = 8'(GAP_L2);
      Lvl3:    gap_reload = 8'(GAP_L3);
      default: gap_reload = 8'(GAP_L1);
    endcase
  end

  // Next-state, row, gap and count logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    gap_d   = gap_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (sel) state_d = StWait;
      end
      StWait: begin
        // Disable wins over a coincident tick.
        if (!sel) begin
          state_d = StIdle;
        end else if (tick) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (gap_q == 8'd0) begin
          row_d   = candidate;
          gap_d   = gap_reload;
          count_d = count_q + 8'd1;
        end else begin
          row_d = '0;
          gap_d = gap_q - 8'd1;
        end
        state_d = StEmit;
      end
      StEmit: begin
        state_d = sel ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clearing on entry makes ROW read 0 from the first idle cycle onward.
    if (state_d == StIdle) begin
      row_d = '0;
      gap_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      down_q  <= 1'b1;
      row_q   <= '0;
      gap_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      down_q  <= down_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      count_q <= count_d;
    end
  end

  assign SC_RANDOM_ROW_GEN_ROW       = row_q;
  assign SC_RANDOM_ROW_GEN_ROW_VALID = (state_q == StEmit);
  assign SC_RANDOM_ROW_GEN_COUNT     = count_q;

endmodule

// File: tb/tb_sc_random_row_gen.sv
// Directed/randomized bench for sc_random_row_gen with a transaction-level row model.
module tb_sc_random_row_gen;

  localparam int unsigned Lanes = 8;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sel    = 1'b0;
  logic             down_n = 1'b1;
  logic [1:0]       lvl    = 2'b01;
  logic [Lanes-1:0] row;
  logic             valid;
  logic [7:0]       count;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  // Reference state
  logic [15:0]      m_lfsr;
  int               m_gap = 0;
  int               m_count = 0;
  logic [Lanes-1:0] last_exp = '0;

  always #10 clk = ~clk;

  sc_random_row_gen #(
    .LANES  (Lanes),
    .SEED   (16'hACE1),
    .GAP_L1 (3),
    .GAP_L2 (2),
    .GAP_L3 (1)
  ) dut (
    .SC_STATEMACHINE_RANDOM_CLOCK_50    (clk),
    .SC_STATEMACHINE_RANDOM_RESET_InLow (rst_n),
    .SC_RANDOM_ROW_GEN_SELECTION        (sel),
    .SC_RANDOM_ROW_GEN_DOWN_InLow       (down_n),
    .SC_RANDOM_ROW_GEN_LEVEL_InLow      (lvl),
    .SC_RANDOM_ROW_GEN_ROW              (row),
    .SC_RANDOM_ROW_GEN_ROW_VALID        (valid),
    .SC_RANDOM_ROW_GEN_COUNT            (count)
  );

  // LFSR value over time: polynomial x^16+x^14+x^13+x^11, one step per clock.
  function automatic logic [15:0] poly_step(input logic [15:0] v);
    int taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb = fb ^ v[taps[i]-1];
    return {v[14:0], fb};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= poly_step(m_lfsr);
  end

  always @(negedge clk) begin
    if (valid === 1'b1) strobes <= strobes + 1;
  end

  function automatic int gap_of(input logic [1:0] lv);
    if (lv == 2'b10) return 2;
    if (lv == 2'b11) return 1;
    return 3;
  endfunction

  function automatic logic [Lanes-1:0] car_row(input logic [15:0] l, input logic [1:0] lv);
    logic [Lanes-1:0] r;
    int a;
    int b;
    a = int'(l) % Lanes;
    b = (int'(l) / Lanes) % Lanes;
    r = '0;
    r[a] = 1'b1;
    if (lv == 2'b11) r[b] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted tick from St_WAIT. hold_low keeps DOWN low afterwards;
  // pulse_in_emit creates a second falling edge during the strobe cycle.
  task automatic tick_and_check(input string tag, input bit hold_low, input bit pulse_in_emit);
    logic [15:0]      l;
    logic [Lanes-1:0] e;
    @(posedge clk); #1 down_n = 1'b0;               // cycle k: tick seen in WAIT
    @(posedge clk); #1 down_n = hold_low ? 1'b0 : 1'b1; // cycle k+1: LOAD
    l = m_lfsr;
    check({tag, " no_valid_in_load"}, 32'(valid), 32'd0);
    if (m_gap == 0) begin
      e = car_row(l, lvl);
      m_gap = gap_of(lvl);
      m_count = (m_count + 1) % 256;
    end else begin
      e = '0;
      m_gap--;
    end
    last_exp = e;
    @(posedge clk); #1;                             // cycle k+2: EMIT
    check({tag, " valid"}, 32'(valid), 32'd1);
    check({tag, " row"}, 32'(row), 32'(e));
    check({tag, " count"}, 32'(count), 32'(m_count));
    if (pulse_in_emit) down_n = 1'b0;
    @(posedge clk); #1 down_n = hold_low ? 1'b0 : 1'b1;
    check({tag, " valid_drop"}, 32'(valid), 32'd0);
    check({tag, " row_hold"}, 32'(row), 32'(e));
  endtask

  initial begin
    int s0;

    // Reset values
    #5;
    check("rst_row", 32'(row), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Generation disabled: ticks ignored
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 down_n = 1'b0;
      @(posedge clk); #1 down_n = 1'b1;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    check("off_strobes", 32'(strobes), 32'd0);
    check("off_row", 32'(row), 32'd0);
    check("off_count", 32'(count), 32'd0);

    // Level 1: car,0,0,0 pattern
    sel = 1'b1;
    lvl = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    s0 = strobes;
    for (int i = 0; i < 8; i++) begin
      tick_and_check("lvl1", 1'b0, 1'b0);
      check("lvl1_nonempty", 32'(row != '0), 32'((i % 4) == 0));
      repeat ($urandom_range(1, 17)) @(posedge clk);
    end
    #1;
    check("lvl1_count", 32'(count), 32'd2);
    check("lvl1_strobes", 32'(strobes - s0), 32'd8);

    // Level 3: car/empty alternation, up to two cars
    lvl = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick_and_check("lvl3", 1'b0, 1'b0);
      check("lvl3_alt", 32'(row != '0), 32'((i % 2) == 0));
      repeat ($urandom_range(1, 17)) @(posedge clk);
    end
    #1;
    check("lvl3_count", 32'(count), 32'd7);

    // DOWN held low: one strobe only
    lvl = 2'(($urandom_range(0, 3)));
    #1 s0 = strobes;
    tick_and_check("hold", 1'b1, 1'b0);
    repeat (47) @(posedge clk);
    #1 down_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_one_strobe", 32'(strobes - s0), 32'd1);

    // Tick landing in the strobe cycle is dropped
    s0 = strobes;
    tick_and_check("drop", 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("drop_one_strobe", 32'(strobes - s0), 32'd1);

    // Make sure a car row is showing before disabling
    lvl = 2'b11;
    for (int i = 0; i < 4 && last_exp == '0; i++) tick_and_check("prep", 1'b0, 1'b0);
    check("prep_car", 32'(row != '0), 32'd1);

    // SELECTION drops with a coincident tick
    s0 = strobes;
    @(posedge clk); #1 down_n = 1'b0; sel = 1'b0;
    @(posedge clk); #1 down_n = 1'b1;
    check("dis_row_first_idle", 32'(row), 32'd0);
    check("dis_valid", 32'(valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("dis_no_strobe", 32'(strobes - s0), 32'd0);
    m_gap = 0;
    sel = 1'b1;
    lvl = 2'b10;
    repeat (2) @(posedge clk);
    tick_and_check("reen", 1'b0, 1'b0);
    check("reen_car", 32'(row != '0), 32'd1);

    // Async reset in St_LOAD
    s0 = strobes;
    @(posedge clk); #1 down_n = 1'b0;
    @(posedge clk); #1 down_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("arst_row", 32'(row), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("arst_no_strobe", 32'(strobes - s0), 32'd0);
    m_gap = 0;
    m_count = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      lvl = 2'(($urandom_range(0, 3)));
      tick_and_check("post_rst", 1'b0, 1'b0);
      repeat ($urandom_range(0, 9)) @(posedge clk);
    end

    // COUNT wrap
    lvl = 2'b11;
    while (m_count != 255) begin
      tick_and_check("wrap_fill", 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int i = 0; i < 4; i++) tick_and_check("wrap", 1'b0, 1'b0);
    #1;
    check("wrap_count", 32'(count), 32'(m_count));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
